reg_file: RTL and testbench



---
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 8 x 16-bit register file with two registered read ports and one write port.
// r0 is hardwired to zero. Read data is registered (one-cycle latency), and a write to
// the register being read on the same edge is forwarded to the read output.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears all registers and read outputs
//   i_raddr1  read port 1 index         o_rdata1  read port 1 data (registered)
//   i_raddr2  read port 2 index         o_rdata2  read port 2 data (registered)
//   i_we      write enable
//   i_waddr   write index
//   i_wdata   write data
//   o_dbg_r1  combinational view of r1 contents (no bypass)
module reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_dbg_r1
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // r0 has no storage at all, so nothing on the write inputs can ever make it non-zero.
  logic [DATA_W-1:0] r_regs [1:NumRegs-1];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] w_rdata1_d;
  logic [DATA_W-1:0] w_rdata2_d;

  // Read muxes: index 0 falls through to the zero default. A matching write on the same
  // edge takes priority so decode never sees the stale value.
  always_comb begin
    w_rdata1_d = '0;
    w_rdata2_d = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if (i_raddr1 == ADDR_W'(i)) begin
        w_rdata1_d = (i_we && (i_waddr == ADDR_W'(i))) ? i_wdata : r_regs[i];
      end
      if (i_raddr2 == ADDR_W'(i)) begin
        w_rdata2_d = (i_we && (i_waddr == ADDR_W'(i))) ? i_wdata : r_regs[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        if (i_we && (i_waddr == ADDR_W'(i))) begin
          r_regs[i] <= i_wdata;
        end
      end
      r_rdata1 <= w_rdata1_d;
      r_rdata2 <= w_rdata2_d;
    end
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;
  assign o_dbg_r1 = r_regs[1];

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] dbg_r1;

  int n_tests;
  int n_fail;

  reg_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raddr1(raddr1),
    .o_rdata1(rdata1),
    .i_raddr2(raddr2),
    .o_rdata2(rdata2),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .o_dbg_r1(dbg_r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;
    logic [DATA_W-1:0] exp_dbg;
  } vec_t;

  // Reference contents of the register file, written only by spec rules.
  logic [DATA_W-1:0] model [8];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] ra,
                                                   input logic w_en,
                                                   input logic [ADDR_W-1:0] wa,
                                                   input logic [DATA_W-1:0] wd);
    if (ra == 0) return '0;
    if (w_en && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic drive(input logic w_en, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra1,
                       input logic [ADDR_W-1:0] ra2);
    we = w_en; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
  endtask

  initial begin
    vec_t vecs[9];
    logic [DATA_W-1:0] e1, e2;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 3'd5, 16'h1234, 3'd0, 3'd5, 16'h0000, 16'h1234, 16'h0000};
    vecs[4] = '{1'b0, 3'd2, 16'hAAAA, 3'd2, 3'd5, 16'h0000, 16'h1234, 16'h0000};
    vecs[5] = '{1'b1, 3'd4, 16'h0042, 3'd4, 3'd4, 16'h0042, 16'h0042, 16'h0000};
    vecs[6] = '{1'b1, 3'd7, 16'h8000, 3'd4, 3'd7, 16'h0042, 16'h8000, 16'h0000};
    vecs[7] = '{1'b1, 3'd1, 16'h5A5A, 3'd1, 3'd7, 16'h5A5A, 16'h8000, 16'h5A5A};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd1, 16'h5A5A, 16'h5A5A, 16'h5A5A};

    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_rdata1", rdata1, '0);
    check("reset_rdata2", rdata2, '0);
    check("reset_dbg",    dbg_r1, '0);
    rst_n = 1'b1;

    // Directed table: each row is applied at a negedge and checked one negedge later.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
      @(negedge clk);
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
      check($sformatf("vec%0d_dbg", i),    dbg_r1, vecs[i].exp_dbg);
    end
    model[1] = 16'h5A5A; model[3] = 16'hBEEF; model[4] = 16'h0042;
    model[5] = 16'h1234; model[7] = 16'h8000;

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
            DATA_W'($urandom), ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      e1 = model_read(raddr1, we, waddr, wdata);
      e2 = model_read(raddr2, we, waddr, wdata);
      if (we && waddr != 0) model[waddr] = wdata;
      @(negedge clk);
      check("rand_rdata1", rdata1, e1);
      check("rand_rdata2", rdata2, e2);
      check("rand_dbg",    dbg_r1, model[1]);
    end

    // Make sure r1 and outputs are non-zero, then reset mid-cycle.
    drive(1'b1, 3'd1, 16'hC0DE, 3'd1, 3'd1);
    @(negedge clk);
    check("pre_reset_dbg", dbg_r1, 16'hC0DE);
    drive(1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rdata1", rdata1, '0);
    check("async_rdata2", rdata2, '0);
    check("async_dbg",    dbg_r1, '0);
    @(posedge clk);  // edge with we=1 while held in reset must not write
    #1;
    check("held_dbg",    dbg_r1, '0);
    check("held_rdata1", rdata1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, ADDR_W'(i), ADDR_W'(7 - i));
      @(negedge clk);
      check($sformatf("post_reset_r%0d_p1", i), rdata1, '0);
      check($sformatf("post_reset_r%0d_p2", 7 - i), rdata2, '0);
    end
    check("post_reset_dbg", dbg_r1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
